// File: rtl/dzcpu_useq_pkg.sv
// Shared encodings for the dzcpu microcode sequencer: flow codes, FSM states,
// and the bit layout of a microcode ROM word.
package dzcpu_useq_pkg;

  localparam int UOP_W    = 12;
  localparam int FLOW_MSB = 11;
  localparam int FLOW_LSB = 9;
  localparam int OP_MSB   = 8;

  typedef enum logic [2:0] {
    FL_OP        = 3'd0,
    FL_INC       = 3'd1,
    FL_EOF       = 3'd2,
    FL_INC_EOF   = 3'd3,
    FL_INC_EOF_Z = 3'd4,
    FL_JCB       = 3'd5,
    FL_NOP       = 3'd6,
    FL_ILLEGAL   = 3'd7
  } flow_e;

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_DECODE    = 2'd1,
    S_EXEC      = 2'd2,
    S_CB_DECODE = 2'd3
  } state_e;

endpackage

// File: rtl/dzcpu_useq_flow_dec.sv
// Combinational decode of the 3-bit uop flow field into sequencer controls.
module dzcpu_useq_flow_dec
  import dzcpu_useq_pkg::*;
(
  input  logic [2:0] flow,
  input  logic       zero,
  output logic       advance,
  output logic       pc_inc,
  output logic       flow_end,
  output logic       cb,
  output logic       err
);

  always_comb begin
    advance  = 1'b0;
    pc_inc   = 1'b0;
    flow_end = 1'b0;
    cb       = 1'b0;
    err      = 1'b0;
    case (flow_e'(flow))
      FL_OP, FL_NOP: advance = 1'b1;
      FL_INC: begin
        advance = 1'b1;
        pc_inc  = 1'b1;
      end
      FL_EOF: flow_end = 1'b1;
      FL_INC_EOF: begin
        pc_inc   = 1'b1;
        flow_end = 1'b1;
      end
      // conditional early exit: Z set ends the flow, otherwise fall through
      FL_INC_EOF_Z: begin
        pc_inc   = 1'b1;
        flow_end = zero;
        advance  = ~zero;
      end
      FL_JCB: begin
        pc_inc = 1'b1;
        cb     = 1'b1;
      end
      FL_ILLEGAL: begin
        err      = 1'b1;
        flow_end = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: fetch -> LUT decode -> step uPC through ROM to eof.
// Interrupt entry at end of flow is built only with DZCPU_USEQ_IRQ_EN defined.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter logic [7:0] IRQ_FLOW_IDX = 8'd90,
  parameter int         CYC_W        = 8
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMemData,
  input  logic             iMemReady,
  input  logic             iStall,
  input  logic [7:0]       iFlowIdx,
  input  logic [7:0]       iCbFlowIdx,
  input  logic [11:0]      iUop,
  input  logic             iZeroFlag,
  input  logic             iIrqReq,
  output logic [7:0]       oUopAddr,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFetch,
  output logic [7:0]       oMop,
  output logic [7:0]       oCbMop,
  output logic             oInstrDone,
  output logic [CYC_W-1:0] oInstrCycles,
  output logic             oIrqAck,
  output logic             oUopErr
);

  state_e           state, state_nxt;
  logic [7:0]       upc, upc_nxt;
  logic [CYC_W-1:0] cyc, cyc_nxt, cyc_inc, cycles_nxt;
  logic [7:0]       mop_nxt, cb_nxt;
  logic             done_nxt, ack_nxt, err_nxt;
  logic             dec_adv, dec_pc_inc, dec_end, dec_cb, dec_err;

  // datapath consumes the operand field directly from the ROM
  logic unused_op;
  assign unused_op = ^iUop[OP_MSB:0];

  dzcpu_useq_flow_dec u_flow_dec (
    .flow     (iUop[FLOW_MSB:FLOW_LSB]),
    .zero     (iZeroFlag),
    .advance  (dec_adv),
    .pc_inc   (dec_pc_inc),
    .flow_end (dec_end),
    .cb       (dec_cb),
    .err      (dec_err)
  );

  assign cyc_inc  = (&cyc) ? cyc : cyc + {{(CYC_W-1){1'b0}}, 1'b1};
  assign oUopAddr = upc;

`ifdef DZCPU_USEQ_IRQ_EN
  logic in_irq, in_irq_nxt;
`else
  logic unused_irq;
  assign unused_irq = iIrqReq;
`endif

  always_comb begin
    state_nxt  = state;
    upc_nxt    = upc;
    cyc_nxt    = cyc;
    mop_nxt    = oMop;
    cb_nxt     = oCbMop;
    cycles_nxt = oInstrCycles;
    err_nxt    = oUopErr;
    done_nxt   = 1'b0;
    ack_nxt    = 1'b0;
    oUopValid  = 1'b0;
    oPcInc     = 1'b0;
    oFetch     = 1'b0;
`ifdef DZCPU_USEQ_IRQ_EN
    in_irq_nxt = in_irq;
`endif
    if (!iStall) begin
      case (state)
        S_FETCH: begin
          oFetch = 1'b1;
          if (iMemReady) begin
            mop_nxt   = iMemData;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          upc_nxt   = iFlowIdx;
          cyc_nxt   = '0;
          state_nxt = S_EXEC;
        end
        S_CB_DECODE: begin
          upc_nxt   = iCbFlowIdx;
          state_nxt = S_EXEC;
        end
        S_EXEC: begin
          oUopValid = 1'b1;
          oPcInc    = dec_pc_inc;
          cyc_nxt   = cyc_inc;
          if (dec_adv) upc_nxt = upc + 8'd1;
          if (dec_err) err_nxt = 1'b1;
          if (dec_cb) begin
            cb_nxt    = iMemData;
            state_nxt = S_CB_DECODE;
          end
          if (dec_end) begin
            state_nxt  = S_FETCH;
            done_nxt   = 1'b1;
            cycles_nxt = cyc_inc;
`ifdef DZCPU_USEQ_IRQ_EN
            // a completed IRQ flow never chains straight into another one
            if (in_irq) begin
              in_irq_nxt = 1'b0;
            end else if (iIrqReq) begin
              state_nxt  = S_EXEC;
              upc_nxt    = IRQ_FLOW_IDX;
              cyc_nxt    = '0;
              ack_nxt    = 1'b1;
              in_irq_nxt = 1'b1;
            end
`endif
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state        <= S_FETCH;
      upc          <= '0;
      cyc          <= '0;
      oMop         <= '0;
      oCbMop       <= '0;
      oInstrDone   <= 1'b0;
      oInstrCycles <= '0;
      oIrqAck      <= 1'b0;
      oUopErr      <= 1'b0;
    end else begin
      state        <= state_nxt;
      upc          <= upc_nxt;
      cyc          <= cyc_nxt;
      oMop         <= mop_nxt;
      oCbMop       <= cb_nxt;
      oInstrDone   <= done_nxt;
      oInstrCycles <= cycles_nxt;
      oIrqAck      <= ack_nxt;
      oUopErr      <= err_nxt;
    end
  end

`ifdef DZCPU_USEQ_IRQ_EN
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) in_irq <= 1'b0;
    else         in_irq <= in_irq_nxt;
  end
`endif

endmodule

// File: doc/dzcpu_useq.md
# dzcpu_useq

Microcode sequencer for the dzcpu core: fetches each macro-opcode, maps it to a micro-flow entry through the opcode LUTs, and steps the micro-PC through the microcode ROM until end-of-flow. Sits between the memory/fetch path and the microcode LUT/ROM and drives the datapath's per-uop strobes. Handles 0xCB prefix redirection, conditional early exit (JR-class), instruction cycle accounting and, optionally, interrupt entry.

## Interface
- IRQ_FLOW_IDX, 8'd90: ROM index of the interrupt-entry micro-flow.
- CYC_W, 8: width of the per-instruction cycle counter.
- iClock  in  1  core clock.
- iReset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- iMemData  in  8  memory read data (opcode / CB byte).
- iMemReady  in  1  iMemData valid this cycle.
- iStall  in  1  freeze sequencer (memory wait).
- iFlowIdx  in  8  main LUT output for oMop.
- iCbFlowIdx  in  8  CB LUT output for oCbMop.
- iUop  in  12  ROM word at oUopAddr; [11:9] flow field, [8:0] datapath op/operand.
- iZeroFlag  in  1  Z flag from datapath.
- iIrqReq  in  1  pending enabled interrupt (level).
- oUopAddr  out  8  micro-PC to ROM.
- oUopValid  out  1  datapath executes iUop[8:0] this cycle.
- oPcInc  out  1  increment PC this cycle.
- oFetch  out  1  request opcode read at PC.
- oMop  out  8  latched opcode, to main LUT.
- oCbMop  out  8  latched CB byte, to CB LUT.
- oInstrDone  out  1  one-cycle pulse after final uop.
- oInstrCycles  out  CYC_W  EXEC cycles of last instruction, valid with oInstrDone.
- oIrqAck  out  1  one-cycle pulse on interrupt entry.
- oUopErr  out  1  sticky: illegal flow code seen.

## Operation
- Flow codes (iUop[11:9]): 0 op, 1 inc, 2 eof, 3 inc_eof, 4 inc_eof_z, 5 jcb, 6 nop, 7 illegal.
- States: FETCH, DECODE, EXEC, CB_DECODE.
- FETCH: oFetch=1; on iMemReady latch iMemData->oMop, go DECODE.
- DECODE: uPC<=iFlowIdx, cycle counter<=0, go EXEC.
- EXEC (per non-stalled cycle): oUopValid=1, counter+1 (saturate at all-ones).
  - op/nop: uPC+1.
  - inc: uPC+1, oPcInc=1.
  - eof: end of flow.
  - inc_eof: oPcInc=1, end.
  - inc_eof_z: oPcInc=1; iZeroFlag=1 -> end; else uPC+1.
  - jcb: oPcInc=1, latch iMemData->oCbMop, go CB_DECODE.
  - illegal: set oUopErr, treat as eof.
- CB_DECODE: uPC<=iCbFlowIdx, go EXEC (counter continues).
- End of flow: next state FETCH, oInstrDone pulse next cycle with oInstrCycles.
- iStall=1: state, uPC, counter, latches hold; oUopValid, oPcInc, oFetch forced 0.

## Timing
- Reset: state FETCH, uPC 0, oMop 8'h00, oCbMop 0, oInstrCycles 0, all strobes 0, oUopErr 0.
- Opcode accepted at edge N -> DECODE cycle N+1 -> first uop valid N+2.
- Flow decode combinational on iUop; uPC/state update at next edge. One uop per cycle.
- Minimum instruction: 3 cycles (FETCH, DECODE, one EXEC).
- uPC 8'hFF +1 wraps to 0 (flow 0 ends with eof; no error raised).
- iMemReady during iStall ignored. Reset mid-flow aborts instantly, no oInstrDone.

## Configuration
- DZCPU_USEQ_IRQ_EN defined: at any ending uop (eof, inc_eof, inc_eof_z taken, illegal) with iIrqReq=1 and not already in the IRQ flow, next state EXEC at IRQ_FLOW_IDX (skips FETCH), oIrqAck pulses that edge; oInstrDone still pulses for the completed instruction. iIrqReq ignored until IRQ flow ends.
- Undefined: iIrqReq ignored, oIrqAck tied 0.

## Structure
- Package dzcpu_useq_pkg: flow-code constants, state encoding, uop field bit positions.
- Sub-module dzcpu_useq_flow_dec: combinational flow-field decode to {advance, pc_inc, end, cb, err}.
- LUTs and ROM stay external, connected via oMop/oCbMop/oUopAddr.

## Test plan
- Opcode 8'h31 (LDSPnn, flow 1, inc,inc,op,inc_eof) -> oUopAddr 1,2,3,4; oPcInc 3 times; oInstrCycles=4.
- 8'hCB then 8'h7C with CB LUT=16 -> jcb at uPC 15, oCbMop=8'h7C, next uop addr 16, oInstrCycles=4.
- JRNZ flow 17: iZeroFlag=1 -> ends at 19 (3 cycles); iZeroFlag=0 -> runs to 22 (6 cycles).
- iStall held 3 cycles mid-flow -> uPC frozen, no strobes, oInstrCycles unchanged vs unstalled run.
- iUop flow=7 -> oUopErr sets and stays, returns to FETCH; reset clears it.
- IRQ_EN: iIrqReq=1 during flow-0 eof -> oIrqAck pulse, next oUopAddr=90, no oFetch between.
